// File: rtl/wb_initiator_pkg.sv
// Shared definitions for the Wishbone classic initiator.
package wb_initiator_pkg;

`ifdef RV64I
  localparam int unsigned DEFAULT_DATA_SIZE = 64;
`else
  localparam int unsigned DEFAULT_DATA_SIZE = 32;
`endif
  localparam int unsigned DEFAULT_ADDR_SIZE = 32;

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    GAP,
    BEAT1,
    RESP
  } wb_state_t;

  // Byte distance between the two beats of a double-word access.
  function automatic int unsigned beat_bytes(input int unsigned data_size);
    return data_size / 8;
  endfunction

endpackage

// File: rtl/wb_initiator_if.sv
// Core request/response handshake plus Wishbone classic bus signals.
interface wb_initiator_if #(
  parameter int unsigned DATA_SIZE = wb_initiator_pkg::DEFAULT_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = wb_initiator_pkg::DEFAULT_ADDR_SIZE
) ();

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic                   req_we_i;
  logic                   req_dword_i;
  logic [ADDR_SIZE-1:0]   req_addr_i;
  logic [2*DATA_SIZE-1:0] req_wdata_i;
  logic                   rsp_valid_o;
  logic [2*DATA_SIZE-1:0] rsp_rdata_o;
  logic                   rsp_err_o;

  logic                   CYC_O;
  logic                   STB_O;
  logic                   WE_O;
  logic [ADDR_SIZE-1:0]   ADR_O;
  logic [DATA_SIZE-1:0]   DAT_O;
  logic [DATA_SIZE-1:0]   DAT_I;
  logic                   ACK_I;

  modport master (
    input  req_valid_i, req_we_i, req_dword_i, req_addr_i, req_wdata_i,
    input  DAT_I, ACK_I,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output CYC_O, STB_O, WE_O, ADR_O, DAT_O
  );

  modport slave (
    output req_valid_i, req_we_i, req_dword_i, req_addr_i, req_wdata_i,
    output DAT_I, ACK_I,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  CYC_O, STB_O, WE_O, ADR_O, DAT_O
  );

endinterface

// File: rtl/wb_initiator_counter.sv
// Synchronous parallel-load up/down counter, used as the beat wait timer.
module wb_initiator_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc_enable,
  input  logic             dec_enable,
  output logic [WIDTH-1:0] count
);

  // Load has priority; simultaneous inc and dec cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc_enable && !dec_enable) begin
      count <= count + WIDTH'(1);
    end else if (dec_enable && !inc_enable) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one core request becomes one or two bus beats
// followed by a single-cycle response pulse; stalled beats time out.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned DATA_SIZE     = DEFAULT_DATA_SIZE,
  parameter int unsigned ADDR_SIZE     = DEFAULT_ADDR_SIZE,
  parameter int unsigned TimeoutCycles = 255
) (
  input logic            CLK_I,
  input logic            RST_I,
  wb_initiator_if.master bus
);

  localparam int unsigned          CW        = $clog2(TimeoutCycles + 1);
  // Timeout fires on the edge that would move the counter to TimeoutCycles,
  // so a beat holds STB_O for exactly TimeoutCycles cycles.
  localparam logic [CW-1:0]        WAIT_LAST = CW'(TimeoutCycles - 1);
  localparam logic [ADDR_SIZE-1:0] BEAT_STEP = ADDR_SIZE'(beat_bytes(DATA_SIZE));

  wb_state_t            state;
  logic                 dword_q;
  logic [DATA_SIZE-1:0] wdata_hi_q;
  logic [CW-1:0]        wait_count;
  logic                 in_beat;
  logic                 beat_entry;

  assign bus.req_ready_o = (state == IDLE);
  assign in_beat         = (state == BEAT0) || (state == BEAT1);
  assign beat_entry      = ((state == IDLE) && bus.req_valid_i) || (state == GAP);

  wb_initiator_counter #(
    .WIDTH(CW)
  ) u_wait_counter (
    .clk        (CLK_I),
    .rst_n      (RST_I),
    .load       (beat_entry),
    .load_value ('0),
    .inc_enable (in_beat && !bus.ACK_I),
    .dec_enable (1'b0),
    .count      (wait_count)
  );

  // Transfer sequencing with all bus and response outputs registered.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state           <= IDLE;
      dword_q         <= 1'b0;
      wdata_hi_q      <= '0;
      bus.CYC_O       <= 1'b0;
      bus.STB_O       <= 1'b0;
      bus.WE_O        <= 1'b0;
      bus.ADR_O       <= '0;
      bus.DAT_O       <= '0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_err_o   <= 1'b0;
      bus.rsp_rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            dword_q         <= bus.req_dword_i;
            wdata_hi_q      <= bus.req_wdata_i[2*DATA_SIZE-1:DATA_SIZE];
            bus.WE_O        <= bus.req_we_i;
            bus.ADR_O       <= bus.req_addr_i;
            bus.DAT_O       <= bus.req_wdata_i[DATA_SIZE-1:0];
            bus.CYC_O       <= 1'b1;
            bus.STB_O       <= 1'b1;
            bus.rsp_rdata_o <= '0;
            state           <= BEAT0;
          end
        end
        BEAT0, BEAT1: begin
          if (bus.ACK_I) begin
            bus.CYC_O <= 1'b0;
            bus.STB_O <= 1'b0;
            if (!bus.WE_O) begin
              if (state == BEAT0) begin
                bus.rsp_rdata_o[DATA_SIZE-1:0] <= bus.DAT_I;
              end else begin
                bus.rsp_rdata_o[2*DATA_SIZE-1:DATA_SIZE] <= bus.DAT_I;
              end
            end
            if ((state == BEAT0) && dword_q) begin
              state <= GAP;
            end else begin
              bus.rsp_valid_o <= 1'b1;
              bus.rsp_err_o   <= 1'b0;
              state           <= RESP;
            end
          end else if (wait_count == WAIT_LAST) begin
            bus.CYC_O       <= 1'b0;
            bus.STB_O       <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_rdata_o <= '0;
            state           <= RESP;
          end
        end
        GAP: begin
          // ADR_O still holds the beat-0 address here; the add wraps naturally.
          bus.ADR_O <= bus.ADR_O + BEAT_STEP;
          bus.DAT_O <= wdata_hi_q;
          bus.CYC_O <= 1'b1;
          bus.STB_O <= 1'b1;
          state     <= BEAT1;
        end
        RESP: begin
          bus.rsp_valid_o <= 1'b0;
          bus.rsp_err_o   <= 1'b0;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: vector table, scoreboard of responses,
// hand-written timeout and mid-transfer reset sequences.
module tb_wb_initiator;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wb_initiator_if #(.DATA_SIZE(32), .ADDR_SIZE(32)) bus ();

  wb_initiator #(
    .DATA_SIZE    (32),
    .ADDR_SIZE    (32),
    .TimeoutCycles(8)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst_n),
    .bus  (bus.master)
  );

  typedef struct {
    logic        we;
    logic        dword;
    logic [31:0] addr;
    logic [63:0] wdata;
    int unsigned d0;
    int unsigned d1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] adr1;
    logic [63:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every rsp_valid_o cycle must match the oldest expected response.
  always @(negedge clk) begin : rsp_monitor
    rsp_t e;
    if (bus.rsp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid_o=1 expected no response at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
        check("rsp_err", 64'(bus.rsp_err_o), 64'(e.err));
      end
    end
  end

  task automatic drive_req(input logic we, input logic dword, input logic [31:0] addr,
                           input logic [63:0] wdata);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_dword_i = dword;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = ~we;
    bus.req_dword_i = $urandom_range(1, 0) == 1;
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = {$urandom, $urandom};
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned nb;
    int unsigned waited;
    logic [31:0] adr[2];
    logic [31:0] dat[2];
    logic [31:0] rd[2];
    int unsigned dl[2];
    nb     = v.dword ? 2 : 1;
    adr[0] = v.addr;          adr[1] = v.adr1;
    dat[0] = v.wdata[31:0];   dat[1] = v.wdata[63:32];
    rd[0]  = v.rd0;           rd[1]  = v.rd1;
    dl[0]  = v.d0;            dl[1]  = v.d1;
    check("ready_idle", 64'(bus.req_ready_o), 64'd1);
    sb.push_back('{v.exp_rdata, 1'b0});
    drive_req(v.we, v.dword, v.addr, v.wdata);
    check("ready_busy", 64'(bus.req_ready_o), 64'd0);
    for (int unsigned b = 0; b < nb; b++) begin
      waited = 0;
      forever begin
        check("beat_cyc_stb", 64'({bus.CYC_O, bus.STB_O}), 64'd3);
        check("beat_adr", 64'(bus.ADR_O), 64'(adr[b]));
        check("beat_dat", 64'(bus.DAT_O), 64'(dat[b]));
        check("beat_we", 64'(bus.WE_O), 64'(v.we));
        if (waited == dl[b]) begin
          bus.ACK_I = 1'b1;
          bus.DAT_I = rd[b];
          @(negedge clk);
          break;
        end
        bus.ACK_I = 1'b0;
        bus.DAT_I = $urandom;
        waited++;
        @(negedge clk);
      end
      bus.ACK_I = 1'b0;
      bus.DAT_I = $urandom;
      check("post_ack_cyc_stb", 64'({bus.CYC_O, bus.STB_O}), 64'd0);
      if (b + 1 < nb) @(negedge clk);
    end
    check("rsp_pulse", 64'(bus.rsp_valid_o), 64'd1);
    @(negedge clk);
    check("rsp_one_cycle", 64'(bus.rsp_valid_o), 64'd0);
    check("ready_after", 64'(bus.req_ready_o), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned n;
    //          we    dword addr          wdata                  d0 d1 rd0           rd1           adr1          exp_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h0200BFF8, 64'h0,                 0, 0, 32'h12345678, 32'h00000000, 32'h0200BFFC, 64'h00000000_12345678};
    vecs[1] = '{1'b1, 1'b1, 32'h02004000, 64'hAABBCCDD_11223344, 0, 0, 32'hFFFFFFFF, 32'hEEEEEEEE, 32'h02004004, 64'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h10000010, 64'hDEADBEEF_CAFEF00D, 5, 0, 32'h13579BDF, 32'h00000000, 32'h10000014, 64'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h0200BFF8, 64'h0,                 2, 3, 32'h89ABCDEF, 32'h00000001, 32'h0200BFFC, 64'h00000001_89ABCDEF};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFFFFFC, 64'h0,                 0, 1, 32'h11111111, 32'h22222222, 32'h00000000, 64'h22222222_11111111};
    vecs[5] = '{1'b0, 1'b0, 32'h00000100, 64'h0,                 7, 0, 32'h5A5A5A5A, 32'h00000000, 32'h00000104, 64'h00000000_5A5A5A5A};
    vecs[6] = '{1'b1, 1'b1, 32'hFFFFFFFC, 64'h01234567_89ABCDEF, 7, 7, 32'h0,        32'h0,        32'h00000000, 64'h0};

    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_dword_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.ACK_I       = 1'b0;
    bus.DAT_I       = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_ctrl", 64'({bus.CYC_O, bus.STB_O, bus.WE_O, bus.rsp_valid_o, bus.rsp_err_o}), 64'd0);
    check("reset_adr_dat", {bus.ADR_O, bus.DAT_O}, 64'd0);
    check("reset_rdata", bus.rsp_rdata_o, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.req_ready_o), 64'd1);

    // Timeout on beat 1 of a double-word read; late ACKs afterwards are ignored.
    sb.push_back('{64'h0, 1'b1});
    drive_req(1'b0, 1'b1, 32'h00002000, 64'h0);
    bus.ACK_I = 1'b1;
    bus.DAT_I = 32'h77777777;
    @(negedge clk);
    bus.ACK_I = 1'b0;
    check("timeout_gap", 64'({bus.CYC_O, bus.STB_O}), 64'd0);
    @(negedge clk);
    n = 0;
    while (bus.CYC_O === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("timeout_wait_cycles", 64'(n), 64'd8);
    check("timeout_rsp", 64'(bus.rsp_valid_o), 64'd1);
    bus.ACK_I = 1'b1;
    bus.DAT_I = 32'hBADBAD00;
    @(negedge clk);
    check("late_ack_cyc", 64'(bus.CYC_O), 64'd0);
    check("late_ack_ready", 64'(bus.req_ready_o), 64'd1);
    @(negedge clk);
    check("late_ack_idle", 64'({bus.CYC_O, bus.rsp_valid_o}), 64'd0);
    bus.ACK_I = 1'b0;
    check("timeout_sb_drained", 64'(sb.size()), 64'd0);

    for (int unsigned i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset asserted while beat 1 is waiting: outputs clear without a clock edge.
    drive_req(1'b1, 1'b1, 32'h00003000, 64'h55555555_66666666);
    bus.ACK_I = 1'b1;
    @(negedge clk);
    bus.ACK_I = 1'b0;
    @(negedge clk);
    check("mid_beat1_cyc", 64'({bus.CYC_O, bus.STB_O}), 64'd3);
    check("mid_beat1_adr", 64'(bus.ADR_O), 64'h00003004);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_cyc_stb", 64'({bus.CYC_O, bus.STB_O, bus.WE_O}), 64'd0);
    check("async_reset_adr", 64'(bus.ADR_O), 64'd0);
    check("async_reset_rsp", 64'(bus.rsp_valid_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    run_vec(vecs[0]);
    run_vec(vecs[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
